// File: rtl/fake_mario_pkg.sv
// Shared constants and types for the frame-paced keycode scheduler.
// Holds the register map, status bit positions and drain FSM states.
package fake_mario_pkg;

  localparam int KEY_W = 8;

  localparam logic [1:0] KC_ADDR_DATA = 2'd0;
  localparam logic [1:0] KC_ADDR_STAT = 2'd1;
  localparam logic [1:0] KC_ADDR_HOLD = 2'd2;

  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_VALID_BIT = 11;

  localparam int CTL_CLR_OVF_BIT = 0;
  localparam int CTL_FLUSH_BIT   = 1;

  typedef enum logic {
    IDLE,
    HOLD
  } drain_state_e;

endpackage

// File: rtl/fake_mario_sync_fifo.sv
// Show-ahead synchronous FIFO; the caller guarantees push is only asserted
// when there is room (or a pop happens in the same cycle).
module fake_mario_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [KEY_W-1:0]           din,
  output logic [KEY_W-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // once written, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/fake_mario_keycode_sched.sv
// Avalon-MM keycode buffer that releases one queued keycode per video frame
// and holds it for a programmable number of frames.
module fake_mario_keycode_sched
  import fake_mario_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int KEY_W        = fake_mario_pkg::KEY_W,
  parameter int HOLD_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             frame_tick,
  output logic [KEY_W-1:0] keycode_out,
  output logic             keycode_valid
);

  localparam int AW = $clog2(DEPTH);

  drain_state_e     state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       hold_q, hold_d;

  logic             wr_en, push_req, push_accept, stat_wr, flush, ovf_clr, hold_wr;
  logic             pop;
  logic [7:0]       hold_reload;
  logic [KEY_W-1:0] fifo_dout;
  logic [AW:0]      fifo_count;
  logic             fifo_empty, fifo_full;

  assign wr_en    = chipselect & ~write_n;
  assign push_req = wr_en && (address == KC_ADDR_DATA);
  assign stat_wr  = wr_en && (address == KC_ADDR_STAT);
  assign hold_wr  = wr_en && (address == KC_ADDR_HOLD);
  assign flush    = stat_wr & writedata[CTL_FLUSH_BIT];
  assign ovf_clr  = stat_wr & writedata[CTL_CLR_OVF_BIT];

  // A programmed hold of 0 behaves like 1 so every code is seen for a frame.
  assign hold_reload = ((hold_q == 8'd0) ? 8'd1 : hold_q) - 8'd1;

  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_accept = push_req & (~fifo_full | pop);

  fake_mario_sync_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_accept),
    .pop   (pop),
    .flush (flush),
    .din   (writedata[KEY_W-1:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    key_d      = key_q;
    valid_d    = valid_q;
    pop        = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      key_d      = '0;
      valid_d    = 1'b0;
    end else if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            key_d      = fifo_dout;
            valid_d    = 1'b1;
            hold_cnt_d = hold_reload;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            key_d      = fifo_dout;
            valid_d    = 1'b1;
            hold_cnt_d = hold_reload;
          end else begin
            key_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    else if (push_req && !push_accept) ovf_d = 1'b1;
    hold_d = hold_wr ? writedata[7:0] : hold_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      key_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      hold_q     <= 8'(HOLD_DEFAULT);
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      KC_ADDR_DATA: readdata = 32'(key_q);
      KC_ADDR_STAT: begin
        readdata[7:0]        = 8'(fifo_count);
        readdata[ST_EMPTY_BIT] = fifo_empty;
        readdata[ST_FULL_BIT]  = fifo_full;
        readdata[ST_OVF_BIT]   = ovf_q;
        readdata[ST_VALID_BIT] = valid_q;
      end
      KC_ADDR_HOLD: readdata[7:0] = hold_q;
      default:      readdata = '0;
    endcase
  end

  assign keycode_out   = key_q;
  assign keycode_valid = valid_q;

endmodule

// File: doc/fake_mario_keycode_sched.md
Name: fake_mario_keycode_sched

Overview:
- Avalon-MM slave that buffers keycodes written by the NIOS USB-keyboard driver in a small FIFO.
- Releases one keycode per video frame to the game logic (mario motion / FSM), holding each for a programmable number of frames.
- Decouples bursty software key reports from the frame-synchronous game datapath, so no key press is lost between vsyncs.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- KEY_W, 8, keycode width.
- HOLD_DEFAULT, 1, reset value of the hold register (frames per keycode).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states.
- frame_tick  in  1  one-cycle pulse per frame (vsync rising edge, already in clk domain).
- keycode_out  out  KEY_W  keycode presented to game logic.
- keycode_valid  out  1  high while keycode_out holds a dequeued code.

Behaviour:
- Register map: write = chipselect & ~write_n.
  - addr 0:
    - Write pushes writedata[KEY_W-1:0]; 0x00 is pushed as an ordinary code (explicit release).
    - Read returns keycode_out zero-extended.
  - addr 1:
    - Read: [7:0] count, [8] empty, [9] full, [10] overflow (sticky), [11] keycode_valid.
    - Write: bit0=1 clears overflow; bit1=1 flushes.
  - addr 2:
    - Read/write hold register [7:0].
    - Written value 0 is stored as 0 and treated as 1.
  - addr 3: reads 0; writes ignored.
- Reset: FIFO empty, count 0, overflow 0, hold = HOLD_DEFAULT, keycode_out 0, keycode_valid 0, state IDLE.
- Push rules:
  - Accepted if count < DEPTH, or a pop occurs in the same cycle.
  - Otherwise dropped, overflow <= 1, FIFO unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Drain FSM, updating only on frame_tick; outputs are registered and change on the clk edge after the frame_tick cycle.
  - IDLE, FIFO non-empty:
    - Pop head, keycode_out <= head, keycode_valid <= 1.
    - hold_cnt <= max(hold,1) - 1; go HOLD.
  - IDLE, FIFO empty: no change.
  - HOLD, hold_cnt > 0: hold_cnt--.
  - HOLD, hold_cnt = 0, FIFO non-empty: pop next, reload keycode_out and hold_cnt, stay HOLD.
  - HOLD, hold_cnt = 0, FIFO empty: keycode_out <= 0, keycode_valid <= 0; go IDLE.
- A push and a pop in the same cycle leave count unchanged; the pushed entry lands behind the popped one.
- Hold register writes take effect at the next load; the current hold_cnt is unaffected.
- Flush has priority over a same-cycle push, pop and overflow-clear:
  - FIFO emptied, keycode_out 0, keycode_valid 0, state IDLE, hold_cnt 0.
  - overflow is unchanged unless bit0 is also set.
- Reset asserted mid-HOLD returns everything to reset values on the next evaluation (asynchronous).

Decomposition:
- Package fake_mario_pkg:
  - KEY_W.
  - Register address constants KC_ADDR_DATA=0, KC_ADDR_STAT=1, KC_ADDR_HOLD=2.
  - Status bit index constants.
  - Drain state enum {IDLE, HOLD}.
- Sub-module fake_mario_sync_fifo (DEPTH, KEY_W):
  - Ports push, pop, flush, din, dout (head, show-ahead), count, empty, full.
  - The scheduler owns accept/overflow logic and the FSM.

Test Plan:
- Reset check: after reset, keycode_out=0x00, keycode_valid=0, status read=0x100 (empty), hold read=0x01.
- Basic drain: write 0x1A then 0x07 at addr0, no ticks → status count=2.
  - Tick 1 → keycode_out=0x1A, valid=1.
  - Tick 2 → 0x07.
  - Tick 3 → 0x00, valid=0, status empty.
- Hold timing: write hold=3, push 0x04.
  - keycode_out=0x04 after ticks 1, 2 and 3.
  - 0x00 after tick 4.
  - Writing hold=0 then pushing 0x05 gives a 1-frame hold.
- Overflow: push 0x10..0x17 (8 entries) → full=1.
  - Push 0x2C → dropped, overflow=1, count=8.
  - Write addr1=0x1 → overflow=0.
  - Drain yields 0x10..0x17 in order.
- Full corner: FIFO full, push 0x2C in the same cycle as a frame_tick pop → push accepted, count stays 8, overflow=0, 0x2C drains last.
- Flush and reset mid-operation:
  - In HOLD with 3 queued, write addr1=0x2 → keycode_out=0, valid=0, count=0.
  - Separately, assert reset mid-HOLD → all reset values immediately.
